// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES decryption, one round per clock.
// Round keys are fetched by index from an external store.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e       state_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q;
    logic [127:0] out_data_q;
    logic         out_valid_q;
    logic [127:0] shift_d;
    logic [127:0] add_d;
    logic [127:0] mix_d;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p ^= b[i] ? x : 8'h00;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse affine, then multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] sq;
        logic [7:0] r;
        sq = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    always_comb begin
        shift_d = '0;
        add_d   = '0;
        mix_d   = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shift_d[8*(15-4*c-r) +: 8] = st_q[8*(15-4*((c-r+4)%4)-r) +: 8];
        for (int k = 0; k < 16; k++)
            add_d[8*k +: 8] = inv_sbox(shift_d[8*k +: 8]) ^ rk[8*k +: 8];
        for (int c = 0; c < 4; c++)
            mix_d[32*c +: 32] = inv_mix_col(add_d[32*c +: 32]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    st_q    <= in_data ^ rk;
                    rnd_q   <= 4'(NR - 1);
                    state_q <= ROUND;
                end
                ROUND: begin
                    st_q <= mix_d;
                    if (rnd_q == 4'd1) state_q <= FINAL;
                    else rnd_q <= rnd_q - 4'd1;
                end
                FINAL: begin
                    out_data_q  <= add_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign rk_idx    = state_q == ROUND ? rnd_q : state_q == FINAL ? 4'd0 : 4'(NR);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule
